// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester (I) and the data load/store requester (D) of the pipelined core.
// One transaction runs at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// D normally wins a conflict; a saturating starvation counter forces an I
// grant after STARVE_MAX consecutive D grants that found I waiting.
// All memory-side and response outputs are registered; the stall outputs
// are the only combinational outputs.

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low

    // fetch requester
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    // data requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    // pipeline hold requests
    output logic              stall_if,
    output logic              stall_mem
);

    // Counter widths: the starvation counter must hold STARVE_MAX, the wait
    // counter must hold LAT-1 (at least one bit even when LAT is 1).
    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int WC_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(STARVE_MAX);
    localparam logic [WC_W-1:0] WAIT_LOAD    = WC_W'(LAT - 1);

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_e              state_q,  state_d;
    logic                owner_q,  owner_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [SC_W-1:0]     starve_q, starve_d;
    logic [WC_W-1:0]     wait_q,   wait_d;

    // Registered outputs
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                i_ready_q,   i_ready_d;
    logic                d_ready_q,   d_ready_d;

    // Arbitration decisions taken in IDLE this cycle
    logic                grant_i_s;
    logic                grant_d_s;

    // Next-state, arbitration, starvation tracking and output precomputation
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // I wins when alone, or when D has been favoured too often.
                if (i_req && (!d_req || (starve_q == STARVE_LIMIT))) begin
                    grant_i_s = 1'b1;
                    owner_d   = OWNER_I;
                    we_d      = 1'b0;
                    addr_d    = i_addr;
                    state_d   = S_ISSUE;
                end else if (d_req) begin
                    grant_d_s = 1'b1;
                    owner_d   = OWNER_D;
                    we_d      = d_we;
                    addr_d    = d_addr;
                    wdata_d   = d_wdata;
                    state_d   = S_ISSUE;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_ISSUE: begin
                // Stores complete without a read return; loads wait LAT cycles.
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // The last WAIT cycle is the one in which mem_rdata is valid.
                if (wait_q == {WC_W{1'b0}}) begin
                    if (owner_q == OWNER_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q - WC_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Count D grants that left a fetch waiting; any fetch grant or an
        // absent fetch request clears the history.
        if (grant_i_s) begin
            starve_d = {SC_W{1'b0}};
        end else if (!i_req) begin
            starve_d = {SC_W{1'b0}};
        end else if (grant_d_s && (starve_q != STARVE_LIMIT)) begin
            starve_d = starve_q + SC_W'(1);
        end else begin
            starve_d = starve_q;
        end

        // Memory strobe is a one-cycle pulse aligned with ISSUE; address and
        // write data are refreshed only when a new access is issued.
        mem_en_d = (state_d == S_ISSUE);
        mem_we_d = (state_d == S_ISSUE) && (owner_d == OWNER_D) && we_d;
        if (state_d == S_ISSUE) begin
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end else begin
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end

        // Ready pulse to the owner for the single RESP cycle.
        i_ready_d = (state_d == S_RESP) && (owner_q == OWNER_I);
        d_ready_d = (state_d == S_RESP) && (owner_q == OWNER_D);
    end

    // State, latched request and registered outputs; reset discards any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_I;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            starve_q    <= {SC_W{1'b0}};
            wait_q      <= {WC_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

    // A requester is held until the cycle its ready pulse appears.
    assign stall_if  = i_req & ~i_ready_q;
    assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus, a small latency-LAT
// memory model, and a scoreboard of expected ready pulses that a separate
// monitor pops and compares whenever i_ready or d_ready is seen.

module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LAT        = 2;
    localparam int STARVE_MAX = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LAT        (LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [31:0] mem     [0:63];
    logic [31:0] rd_pipe [0:LAT-1];

    function automatic logic [31:0] pat(input int idx);
        if (idx == 4) return 32'h200A_0005;
        return 32'hC0DE_0000 | idx;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 64; k++) mem[k] <= pat(k);
            for (int k = 0; k < LAT; k++) rd_pipe[k] <= 32'hDEAD_BEEF;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sbq[$];

    task automatic push(input bit is_d, input bit chk_data, input logic [31:0] data, input int at);
        exp_t e;
        e.is_d = is_d; e.chk_data = chk_data; e.data = data; e.at = at;
        sbq.push_back(e);
    endtask

    // Monitor: every ready pulse must match the oldest expected response.
    exp_t me;
    always @(negedge clk) begin
        if (rst && (i_ready || d_ready)) begin
            chk("one_ready", {31'd0, i_ready & d_ready}, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_ready", sbq.size(), 32'd1);
            end else begin
                me = sbq.pop_front();
                chk("ready_port", {31'd0, d_ready}, {31'd0, me.is_d});
                chk("ready_cycle", cyc, me.at);
                if (me.chk_data) chk("rdata", me.is_d ? d_rdata : i_rdata, me.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_d, input int maxc);
        int n = 0;
        while (!(is_d ? d_ready : i_ready) && n < maxc) begin
            step();
            n++;
        end
        chk(is_d ? "d_ready_timeout" : "i_ready_timeout",
            {31'd0, is_d ? d_ready : i_ready}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"},    {31'd0, mem_en},  32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},  32'd0);
        chk({tag, "_mem_addr"},  mem_addr,         32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,        32'd0);
        chk({tag, "_i_rdata"},   i_rdata,          32'd0);
        chk({tag, "_d_rdata"},   d_rdata,          32'd0);
        chk({tag, "_i_ready"},   {31'd0, i_ready}, 32'd0);
        chk({tag, "_d_ready"},   {31'd0, d_ready}, 32'd0);
    endtask

    int b;
    int got;
    int n;

    initial begin
        rst = 1'b0; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        step(); step();

        // ---- fetch 0x10 -> 0x200A0005, ready in cycle 4 ----
        i_req = 1'b1; i_addr = 32'h10; b = cyc;
        push(1'b0, 1'b1, 32'h200A_0005, b + 4);
        @(negedge clk);
        chk("fetch_stall_c0", {31'd0, stall_if}, 32'd1);
        chk("fetch_mem_en_c0", {31'd0, mem_en}, 32'd0);
        step();
        @(negedge clk);
        chk("fetch_mem_en_c1", {31'd0, mem_en}, 32'd1);
        chk("fetch_mem_we_c1", {31'd0, mem_we}, 32'd0);
        chk("fetch_mem_addr_c1", mem_addr, 32'h10);
        step(); step();
        @(negedge clk);
        chk("fetch_stall_c3", {31'd0, stall_if}, 32'd1);
        chk("fetch_mem_en_c3", {31'd0, mem_en}, 32'd0);
        step();
        wait_ready(1'b0, 4);
        chk("fetch_stall_c4", {31'd0, stall_if}, 32'd0);
        i_req = 1'b0;
        step();

        // ---- data load 0x20 ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; b = cyc;
        push(1'b1, 1'b1, 32'hC0DE_0008, b + 4);
        wait_ready(1'b1, 10);
        d_req = 1'b0;
        step();

        // ---- store 0x0C to 0x8, ready in cycle 2 ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h0C; b = cyc;
        push(1'b1, 1'b0, 32'd0, b + 2);
        @(negedge clk);
        chk("store_stall_c0", {31'd0, stall_mem}, 32'd1);
        step();
        @(negedge clk);
        chk("store_mem_en", {31'd0, mem_en}, 32'd1);
        chk("store_mem_we", {31'd0, mem_we}, 32'd1);
        chk("store_mem_addr", mem_addr, 32'h8);
        chk("store_mem_wdata", mem_wdata, 32'h0C);
        step();
        wait_ready(1'b1, 4);
        chk("store_stall_c2", {31'd0, stall_mem}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        step(); step();
        chk("store_mem_word2", mem[2], 32'h0000_000C);
        chk("store_keeps_d_rdata", d_rdata, 32'hC0DE_0008);

        // ---- conflict: D first (ready 4), I granted in 5 (ready 9) ----
        i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_addr = 32'h24; b = cyc;
        push(1'b1, 1'b1, 32'hC0DE_0009, b + 4);
        push(1'b0, 1'b1, 32'hC0DE_0005, b + 9);
        n = 0;
        while ((i_req || d_req) && n < 20) begin
            if (d_ready) d_req = 1'b0;
            if (i_ready) i_req = 1'b0;
            if (cyc == b + 6) chk("conflict_mem_addr_c6", mem_addr, 32'h14);
            if (i_req || d_req) begin
                step();
                n++;
            end
        end
        chk("conflict_done", {30'd0, i_req, d_req}, 32'd0);
        step();

        // ---- starvation, STARVE_MAX=2: D,D,I,D,D,I ----
        d_addr = 32'h40; i_addr = 32'h80; d_req = 1'b1; i_req = 1'b1; b = cyc;
        push(1'b1, 1'b1, 32'hC0DE_0010, b + 4);
        push(1'b1, 1'b1, 32'hC0DE_0011, b + 9);
        push(1'b0, 1'b1, 32'hC0DE_0020, b + 14);
        push(1'b1, 1'b1, 32'hC0DE_0012, b + 19);
        push(1'b1, 1'b1, 32'hC0DE_0013, b + 24);
        push(1'b0, 1'b1, 32'hC0DE_0021, b + 29);
        got = 0; n = 0;
        while (got < 6 && n < 60) begin
            if (d_ready) begin got++; d_addr = d_addr + 32'd4; end
            if (i_ready) begin got++; i_addr = i_addr + 32'd4; end
            if (got < 6) begin
                step();
                n++;
            end
        end
        chk("starve_count", got, 32'd6);
        d_req = 1'b0; i_req = 1'b0;
        step();

        // ---- dropped request: d_req falls in WAIT, pending fetch follows ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; b = cyc;
        push(1'b1, 1'b1, 32'hC0DE_000C, b + 4);
        push(1'b0, 1'b1, 32'hC0DE_0006, b + 9);
        step();
        i_req = 1'b1; i_addr = 32'h18;
        step();
        d_req = 1'b0;
        wait_ready(1'b0, 20);
        i_req = 1'b0;
        step();

        // ---- reset in WAIT: outputs clear, no ready after release ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        step(); step();
        rst = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        step(); step();
        rst = 1'b1;
        repeat (8) step();

        // ---- arbiter is back in IDLE: a store completes in cycle 2 ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h77; b = cyc;
        push(1'b1, 1'b0, 32'd0, b + 2);
        wait_ready(1'b1, 6);
        d_req = 1'b0; d_we = 1'b0;
        step(); step();
        chk("post_reset_mem_word0", mem[0], 32'h0000_0077);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
